// File: rtl/frame_pkg.sv
// Shared constants and state encoding for the sync-byte frame receiver.
// States are plain logic constants so older blocks can compare against them directly.
package frame_pkg;

  localparam int          FRAME_LEN_DEFAULT = 10;
  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int          IDX_W             = 4;

  typedef logic [1:0] state_t;

  localparam state_t HUNT    = 2'd0;
  localparam state_t COLLECT = 2'd1;
  localparam state_t CHECK   = 2'd2;
  localparam state_t HOLD    = 2'd3;

endpackage

// File: rtl/frame_buffer.sv
// Payload register file: one write port, combinational read.
// Addresses at or beyond FRAME_LEN read as zero.
module frame_buffer
  import frame_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [7:0]       rd_data
);

  localparam logic [IDX_W-1:0] LEN = IDX_W'(FRAME_LEN);

  logic [7:0] mem [FRAME_LEN];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FRAME_LEN; i++) mem[i] <= '0;
    end else if (we && (waddr < LEN)) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_addr < LEN) rd_data = mem[rd_addr];
  end

endmodule

// File: rtl/frame_reader.sv
// Hunts for the sync byte, collects a fixed-length payload, verifies the XOR
// checksum and holds a good frame until the consumer acknowledges it.
module frame_reader
  import frame_pkg::*;
#(
  parameter int         FRAME_LEN = FRAME_LEN_DEFAULT,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  input  logic       frame_ack,
  output logic       frame_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic [7:0] err_count,
  output logic       busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       csum;
  logic             buf_we;

  assign buf_we      = (state == COLLECT) && in_valid;
  assign frame_ready = (state == HOLD);
  assign busy        = (state == COLLECT) || (state == CHECK);

  frame_buffer #(.FRAME_LEN(FRAME_LEN)) u_buffer (
    .clk     (clk),
    .reset   (reset),
    .we      (buf_we),
    .waddr   (idx),
    .wdata   (in_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Only valid bytes move the FSM; in HOLD an ack beats a simultaneous byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= HUNT;
      idx       <= '0;
      csum      <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      err_count <= '0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        HUNT: begin
          if (in_valid && (in_data == SYNC_BYTE)) begin
            state <= COLLECT;
            idx   <= '0;
            csum  <= '0;
          end
        end
        COLLECT: begin
          if (in_valid) begin
            csum <= csum ^ in_data;
            idx  <= idx + 4'd1;
            if (idx == LAST_IDX) state <= CHECK;
          end
        end
        CHECK: begin
          if (in_valid) begin
            if (in_data == csum) begin
              state <= HOLD;
            end else begin
              frame_err <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
              state <= HUNT;
            end
          end
        end
        HOLD: begin
          if (frame_ack) begin
            state   <= HUNT;
            overrun <= 1'b0;
          end else if (in_valid) begin
            overrun <= 1'b1;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_reader.sv
// Directed + randomized bench for frame_reader with a frame-level reference model.
module tb_frame_reader;

  localparam int         LEN  = 10;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       frame_ack;
  logic       frame_ready;
  logic       frame_err;
  logic       overrun;
  logic [7:0] err_count;
  logic       busy;

  int n_checks = 0;
  int n_fails  = 0;
  int model_err = 0;
  logic [7:0] payload_q[$];
  logic [7:0] exp_buf [16];

  frame_reader #(.FRAME_LEN(LEN), .SYNC_BYTE(SYNC)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_ack   (frame_ack),
    .frame_ready (frame_ready),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .err_count   (err_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled at the next falling edge.
  task automatic apply_stimulus(input logic [7:0] b, input logic v);
    in_data  = b;
    in_valid = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  function automatic logic [7:0] xor_of_payload();
    logic [7:0] x = 8'h00;
    foreach (payload_q[i]) x ^= payload_q[i];
    return x;
  endfunction

  task automatic fill_seq();
    payload_q.delete();
    for (int i = 0; i < LEN; i++) payload_q.push_back(8'(i + 1));
  endtask

  task automatic fill_random();
    payload_q.delete();
    for (int i = 0; i < LEN; i++) payload_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic send_frame(input logic [7:0] chk, input bit gaps);
    bit good;
    good = (chk == xor_of_payload());
    apply_stimulus(SYNC, 1'b1);
    if (gaps) apply_stimulus(8'h00, 1'b0);
    check_output("busy_after_sync", busy, 1'b1);
    for (int i = 0; i < LEN; i++) begin
      apply_stimulus(payload_q[i], 1'b1);
      exp_buf[i] = payload_q[i];
      if (gaps) apply_stimulus(8'h00, 1'b0);
      check_output("busy_collect", busy, 1'b1);
    end
    apply_stimulus(chk, 1'b1);
    if (!good) model_err = (model_err < 255) ? model_err + 1 : 255;
    check_output("ready_after_chk", frame_ready, good);
    check_output("err_after_chk", frame_err, !good);
    check_output("busy_after_chk", busy, 1'b0);
    check_output("err_count", err_count, model_err);
    apply_stimulus(8'h00, 1'b0);
    check_output("err_pulse_len", frame_err, 1'b0);
    check_output("ready_hold", frame_ready, good);
  endtask

  task automatic check_buffer();
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      check_output($sformatf("rd_data[%0d]", a), rd_data, (a < LEN) ? exp_buf[a] : 8'h00);
    end
    @(negedge clk);
  endtask

  task automatic ack_frame();
    frame_ack = 1'b1;
    apply_stimulus(8'h00, 1'b0);
    frame_ack = 1'b0;
    check_output("ready_after_ack", frame_ready, 1'b0);
    check_output("overrun_after_ack", overrun, 1'b0);
  endtask

  initial begin
    reset = 1'b1; in_data = 8'h00; in_valid = 1'b0; rd_addr = 4'd3; frame_ack = 1'b0;
    foreach (exp_buf[i]) exp_buf[i] = 8'h00;
    repeat (2) @(negedge clk);
    check_output("rst_ready", frame_ready, 1'b0);
    check_output("rst_err", frame_err, 1'b0);
    check_output("rst_overrun", overrun, 1'b0);
    check_output("rst_err_count", err_count, 8'h00);
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_rd_data", rd_data, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] good frame");
    fill_seq();
    send_frame(xor_of_payload(), 1'b0);
    check_buffer();
    ack_frame();

    $display("[TB] bad checksum then good frame");
    send_frame(xor_of_payload() ^ 8'h07, 1'b0);
    apply_stimulus(8'h00, 1'b0);
    check_output("hunt_after_bad", busy, 1'b0);
    send_frame(xor_of_payload(), 1'b0);
    check_buffer();
    ack_frame();

    $display("[TB] noise and gaps");
    apply_stimulus(8'h00, 1'b1);
    apply_stimulus(8'h37, 1'b1);
    check_output("noise_ignored", busy, 1'b0);
    send_frame(xor_of_payload(), 1'b1);
    check_buffer();

    $display("[TB] overrun and ack");
    apply_stimulus(8'h55, 1'b1);
    check_output("overrun_set", overrun, 1'b1);
    check_output("ready_during_overrun", frame_ready, 1'b1);
    check_buffer();
    ack_frame();
    payload_q.delete();
    for (int i = 0; i < LEN; i++) payload_q.push_back(8'h00);
    send_frame(8'h00, 1'b0);
    check_buffer();
    frame_ack = 1'b1;
    apply_stimulus(8'h77, 1'b1);
    frame_ack = 1'b0;
    check_output("ack_wins_overrun", overrun, 1'b0);
    check_output("ack_wins_ready", frame_ready, 1'b0);
    frame_ack = 1'b1;
    apply_stimulus(8'h00, 1'b0);
    frame_ack = 1'b0;
    check_output("ack_outside_hold", busy, 1'b0);

    $display("[TB] random frames");
    for (int f = 0; f < 6; f++) begin
      fill_random();
      if ($urandom_range(0, 2) == 0) send_frame(xor_of_payload() ^ 8'(1 << $urandom_range(0, 7)), $urandom_range(0, 1) == 1);
      else begin
        send_frame(xor_of_payload(), $urandom_range(0, 1) == 1);
        check_buffer();
        ack_frame();
      end
    end

    $display("[TB] reset mid-frame");
    rd_addr = 4'd0;
    apply_stimulus(SYNC, 1'b1);
    apply_stimulus(8'h01, 1'b1);
    apply_stimulus(8'h02, 1'b1);
    #2 reset = 1'b1;
    #1;
    model_err = 0;
    foreach (exp_buf[i]) exp_buf[i] = 8'h00;
    check_output("async_rst_busy", busy, 1'b0);
    check_output("async_rst_err_count", err_count, 8'h00);
    check_output("async_rst_ready", frame_ready, 1'b0);
    check_output("async_rst_rd_data", rd_data, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    fill_seq();
    send_frame(xor_of_payload(), 1'b0);
    check_buffer();
    ack_frame();

    $display("[TB] error counter saturation");
    for (int f = 0; f < 257; f++) begin
      fill_random();
      send_frame(xor_of_payload() ^ 8'h80, 1'b0);
    end
    check_output("err_count_saturated", err_count, 8'hFF);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
